// File: rtl/dijkstra_pkg.sv
// dijkstra_pkg: shared state, edge and INF definitions for the distance relaxation engine
package dijkstra_pkg;
    localparam int DIST_W = 8;
    localparam int NODE_W = 5;
    typedef enum logic [1:0] {IDLE, INIT, RD, CMP} state_t;
    typedef struct packed {
        logic [NODE_W-1:0] u;
        logic [NODE_W-1:0] v;
        logic [DIST_W-1:0] w;
    } edge_t;
    function automatic logic [31:0] inf_of(input int width);
        return (32'd1 << width) - 32'd1;
    endfunction
endpackage

// File: rtl/sat_add_cmp.sv
// sat_add_cmp: saturating du + w and strict improvement test against dv
module sat_add_cmp
    import dijkstra_pkg::*;
#(
    parameter int DATA_WIDTH = DIST_W
) (
    input  logic [DATA_WIDTH-1:0] du,
    input  logic [DATA_WIDTH-1:0] dv,
    input  logic [DATA_WIDTH-1:0] w,
    output logic [DATA_WIDTH-1:0] sum,
    output logic                  update
);
    localparam logic [DATA_WIDTH-1:0] INF = DATA_WIDTH'(inf_of(DATA_WIDTH));
    logic [DATA_WIDTH:0] raw;
    assign raw    = {1'b0, du} + {1'b0, w};
    assign sum    = raw[DATA_WIDTH] ? INF : raw[DATA_WIDTH-1:0];
    assign update = (du != INF) && (sum < dv);
endmodule

// File: rtl/distance_relax_engine.sv
// distance_relax_engine: INIT sweep and one-edge-per-3-cycles relaxation over a dual-port distance memory
module distance_relax_engine
    import dijkstra_pkg::*;
#(
    parameter int DATA_WIDTH = DIST_W,
    parameter int ADDR_WIDTH = NODE_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_init,
    input  logic [ADDR_WIDTH-1:0] src_node,
    output logic                  init_done,
    output logic                  busy,
    input  logic                  edge_valid,
    output logic                  edge_ready,
    input  logic [ADDR_WIDTH-1:0] edge_u,
    input  logic [ADDR_WIDTH-1:0] edge_v,
    input  logic [DATA_WIDTH-1:0] edge_w,
    output logic                  upd_valid,
    output logic [ADDR_WIDTH-1:0] upd_node,
    output logic [ADDR_WIDTH-1:0] upd_pred,
    output logic [DATA_WIDTH-1:0] upd_dist,
    output logic [ADDR_WIDTH-1:0] mem_addr_a,
    output logic [DATA_WIDTH-1:0] mem_data_a,
    output logic                  mem_we_a,
    input  logic [DATA_WIDTH-1:0] mem_q_a,
    output logic [ADDR_WIDTH-1:0] mem_addr_b,
    output logic [DATA_WIDTH-1:0] mem_data_b,
    output logic                  mem_we_b,
    input  logic [DATA_WIDTH-1:0] mem_q_b
);
    localparam logic [DATA_WIDTH-1:0] INF = DATA_WIDTH'(inf_of(DATA_WIDTH));
    state_t                state, state_n;
    edge_t                 e;
    logic [ADDR_WIDTH-1:0] cnt, src, hold_node, hold_pred;
    logic [DATA_WIDTH-1:0] hold_dist, sum;
    logic                  update, upd;
    sat_add_cmp #(.DATA_WIDTH(DATA_WIDTH)) u_sat_add_cmp (
        .du(mem_q_a),
        .dv(mem_q_b),
        .w(e.w),
        .sum(sum),
        .update(update)
    );
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            src       <= '0;
            e         <= '0;
            hold_node <= '0;
            hold_pred <= '0;
            hold_dist <= '0;
        end else begin
            state <= state_n;
            cnt   <= (state == IDLE) ? '0 : (state == INIT) ? cnt + 1'b1 : cnt;
            if (state == IDLE && start_init)
                src <= src_node;
            if (state == IDLE && !start_init && edge_valid)
                e <= '{u: edge_u, v: edge_v, w: edge_w};
            if (upd) begin
                hold_node <= e.v;
                hold_pred <= e.u;
                hold_dist <= sum;
            end
        end
    end
    // Outputs are decoded from state and forced quiet while reset is held.
    always_comb begin
        state_n    = state;
        edge_ready = 1'b0;
        init_done  = 1'b0;
        upd        = 1'b0;
        mem_addr_a = '0;
        mem_data_a = '0;
        mem_we_a   = 1'b0;
        mem_addr_b = '0;
        mem_data_b = '0;
        mem_we_b   = 1'b0;
        case (state)
            IDLE: begin
                edge_ready = !start_init;
                state_n    = start_init ? INIT : edge_valid ? RD : IDLE;
            end
            INIT: begin
                mem_we_a   = 1'b1;
                mem_addr_a = cnt;
                mem_data_a = (cnt == src) ? '0 : INF;
                init_done  = &cnt;
                state_n    = (&cnt) ? IDLE : INIT;
            end
            RD: begin
                mem_addr_a = e.u;
                mem_addr_b = e.v;
                state_n    = CMP;
            end
            CMP: begin
                mem_addr_b = e.v;
                mem_data_b = sum;
                mem_we_b   = update;
                upd        = update;
                state_n    = IDLE;
            end
            default: state_n = IDLE;
        endcase
        if (reset) begin
            edge_ready = 1'b0;
            init_done  = 1'b0;
            upd        = 1'b0;
            mem_addr_a = '0;
            mem_data_a = '0;
            mem_we_a   = 1'b0;
            mem_addr_b = '0;
            mem_data_b = '0;
            mem_we_b   = 1'b0;
        end
    end
    assign busy      = !reset && (state != IDLE);
    assign upd_valid = upd;
    assign upd_node  = reset ? '0 : upd ? e.v : hold_node;
    assign upd_pred  = reset ? '0 : upd ? e.u : hold_pred;
    assign upd_dist  = reset ? '0 : upd ? sum : hold_dist;
endmodule

// File: tb/tb_distance_relax_engine.sv
// tb_distance_relax_engine: directed checks of INIT, relaxation, priority and reset behaviour
module tb_distance_relax_engine;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start_init = 1'b0;
    logic       edge_valid = 1'b0;
    logic [4:0] src_node = '0;
    logic [4:0] edge_u = '0;
    logic [4:0] edge_v = '0;
    logic [7:0] edge_w = '0;
    logic       init_done, busy, edge_ready, upd_valid;
    logic [4:0] upd_node, upd_pred, mem_addr_a, mem_addr_b;
    logic [7:0] upd_dist, mem_data_a, mem_data_b, mem_q_a, mem_q_b;
    logic       mem_we_a, mem_we_b;
    logic [7:0] mem [32];
    int         n_chk = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    distance_relax_engine dut (
        .clk(clk), .reset(reset), .start_init(start_init), .src_node(src_node),
        .init_done(init_done), .busy(busy), .edge_valid(edge_valid), .edge_ready(edge_ready),
        .edge_u(edge_u), .edge_v(edge_v), .edge_w(edge_w),
        .upd_valid(upd_valid), .upd_node(upd_node), .upd_pred(upd_pred), .upd_dist(upd_dist),
        .mem_addr_a(mem_addr_a), .mem_data_a(mem_data_a), .mem_we_a(mem_we_a), .mem_q_a(mem_q_a),
        .mem_addr_b(mem_addr_b), .mem_data_b(mem_data_b), .mem_we_b(mem_we_b), .mem_q_b(mem_q_b)
    );

    always @(posedge clk) begin
        if (mem_we_a) mem[mem_addr_a] <= mem_data_a;
        if (mem_we_b) mem[mem_addr_b] <= mem_data_b;
        mem_q_a <= mem_we_a ? mem_data_a : mem[mem_addr_a];
        mem_q_b <= mem_we_b ? mem_data_b : mem[mem_addr_b];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_init(input logic [4:0] s, output int lat, output logic busy_ok);
        @(negedge clk);
        start_init = 1'b1;
        src_node   = s;
        @(negedge clk);
        start_init = 1'b0;
        lat        = 1;
        busy_ok    = 1'b1;
        while (!init_done && lat < 100) begin
            busy_ok &= busy;
            @(negedge clk);
            lat++;
        end
        busy_ok &= busy;
    endtask

    task automatic send_edge(input logic [4:0] u, input logic [4:0] v, input logic [7:0] w,
                             output logic uv, output logic we, output logic [4:0] un,
                             output logic [4:0] up, output logic [7:0] ud);
        @(negedge clk);
        edge_valid = 1'b1;
        edge_u     = u;
        edge_v     = v;
        edge_w     = w;
        @(negedge clk);
        edge_valid = 1'b0;
        @(negedge clk);
        uv = upd_valid;
        we = mem_we_b;
        un = upd_node;
        up = upd_pred;
        ud = upd_dist;
        @(negedge clk);
    endtask

    initial begin
        int         lat;
        logic       busy_ok, rdy_seen, uv, we;
        logic [4:0] un, up;
        logic [7:0] ud;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_ready", edge_ready, 0);
        check("rst_we_a", mem_we_a, 0);
        check("rst_we_b", mem_we_b, 0);
        check("rst_done", init_done, 0);
        check("rst_upd", upd_valid, 0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_ready", edge_ready, 1);

        do_init(5'd3, lat, busy_ok);
        check("init3_lat", lat, 32);
        check("init3_busy", busy_ok, 1);
        @(negedge clk);
        check("init3_idle", busy, 0);
        for (int i = 0; i < 32; i++)
            check($sformatf("init3_mem%0d", i), mem[i], (i == 3) ? 0 : 255);

        do_init(5'd0, lat, busy_ok);
        check("init0_lat", lat, 32);
        send_edge(5'd0, 5'd1, 8'd5, uv, we, un, up, ud);
        check("e015_valid", uv, 1);
        check("e015_we", we, 1);
        check("e015_node", un, 1);
        check("e015_pred", up, 0);
        check("e015_dist", ud, 5);
        send_edge(5'd1, 5'd2, 8'd7, uv, we, un, up, ud);
        check("e127_valid", uv, 1);
        check("e127_node", un, 2);
        check("e127_pred", up, 1);
        check("e127_dist", ud, 12);
        check("mem1_5", mem[1], 5);
        check("mem2_12", mem[2], 12);
        send_edge(5'd0, 5'd1, 8'd9, uv, we, un, up, ud);
        check("e019_valid", uv, 0);
        check("e019_we", we, 0);
        check("e019_hold_node", un, 2);
        check("e019_hold_dist", ud, 12);
        check("e019_mem1", mem[1], 5);
        send_edge(5'd0, 5'd1, 8'd4, uv, we, un, up, ud);
        check("e014_valid", uv, 1);
        check("e014_dist", ud, 4);
        check("e014_mem1", mem[1], 4);
        send_edge(5'd5, 5'd6, 8'd0, uv, we, un, up, ud);
        check("unreach_valid", uv, 0);
        check("unreach_we", we, 0);
        send_edge(5'd0, 5'd7, 8'd250, uv, we, un, up, ud);
        check("e07_dist", ud, 250);
        send_edge(5'd7, 5'd8, 8'd10, uv, we, un, up, ud);
        check("sat_valid", uv, 0);
        check("sat_we", we, 0);
        check("sat_mem8", mem[8], 255);
        send_edge(5'd1, 5'd1, 8'd0, uv, we, un, up, ud);
        check("self_valid", uv, 0);
        send_edge(5'd1, 5'd2, 8'd0, uv, we, un, up, ud);
        check("zero_w_valid", uv, 1);
        check("zero_w_dist", ud, 4);
        check("zero_w_mem2", mem[2], 4);

        @(negedge clk);
        start_init = 1'b1;
        src_node   = 5'd0;
        edge_valid = 1'b1;
        edge_u     = 5'd0;
        edge_v     = 5'd3;
        edge_w     = 8'd1;
        #1 check("prio_ready", edge_ready, 0);
        @(negedge clk);
        start_init = 1'b0;
        lat        = 1;
        rdy_seen   = 1'b0;
        while (!init_done && lat < 100) begin
            rdy_seen |= edge_ready;
            @(negedge clk);
            lat++;
        end
        check("prio_lat", lat, 32);
        check("prio_ready_init", rdy_seen, 0);
        @(negedge clk);
        check("prio_accept", edge_ready, 1);
        @(negedge clk);
        edge_valid = 1'b0;
        check("prio_rd_busy", busy, 1);
        @(negedge clk);
        check("prio_valid", upd_valid, 1);
        check("prio_node", upd_node, 3);
        check("prio_pred", upd_pred, 0);
        check("prio_dist", upd_dist, 1);
        @(negedge clk);

        @(negedge clk);
        edge_valid = 1'b1;
        edge_u     = 5'd0;
        edge_v     = 5'd4;
        edge_w     = 8'd2;
        @(negedge clk);
        edge_valid = 1'b0;
        @(negedge clk);
        check("cmp_pre_we", mem_we_b, 1);
        reset = 1'b1;
        #1;
        check("cmp_rst_we", mem_we_b, 0);
        check("cmp_rst_upd", upd_valid, 0);
        check("cmp_rst_busy", busy, 0);
        @(negedge clk);
        check("cmp_post_we_a", mem_we_a, 0);
        check("cmp_post_we_b", mem_we_b, 0);
        check("cmp_post_ready", edge_ready, 0);
        reset = 1'b0;
        @(negedge clk);
        check("cmp_post_mem4", mem[4], 255);
        check("cmp_post_idle", busy, 0);
        check("cmp_post_rdy", edge_ready, 1);

        @(negedge clk);
        start_init = 1'b1;
        src_node   = 5'd0;
        @(negedge clk);
        start_init = 1'b0;
        repeat (10) @(negedge clk);
        check("mid_init_we", mem_we_a, 1);
        check("mid_init_addr", mem_addr_a, 10);
        reset = 1'b1;
        #1;
        check("mid_rst_we", mem_we_a, 0);
        check("mid_rst_addr", mem_addr_a, 0);
        check("mid_rst_busy", busy, 0);
        @(negedge clk);
        check("mid_post_we", mem_we_a, 0);
        check("mid_post_done", init_done, 0);
        reset = 1'b0;
        @(negedge clk);
        check("mid_idle_busy", busy, 0);
        check("mid_idle_ready", edge_ready, 1);
        check("mid_idle_we", mem_we_a, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/distance_relax_engine.md
Name: distance_relax_engine

Overview:
Control stage directly upstream of the dual-port distance memory. It owns both memory ports and performs two operations. INIT clears every distance to INF and the source node to 0. RELAX applies one edge relaxation per accepted edge (u, v, w): if dist[u] + w < dist[v], then dist[v] is updated. Each accepted update is reported downstream to the node-selection/predecessor logic.

Parameters:
DATA_WIDTH, 8, distance and weight width; INF = all ones (2**DATA_WIDTH-1)
ADDR_WIDTH, 5, node index width; node count N = 2**ADDR_WIDTH

Ports:
clk  in  1  single clock, rising edge
reset  in  1  synchronous, active-high
start_init  in  1  pulse; accepted only when idle
src_node  in  ADDR_WIDTH  source node, sampled with start_init
init_done  out  1  one-cycle pulse after the last INIT write
busy  out  1  high in any state other than IDLE
edge_valid  in  1  edge offered
edge_ready  out  1  engine can accept an edge this cycle
edge_u  in  ADDR_WIDTH  edge tail
edge_v  in  ADDR_WIDTH  edge head
edge_w  in  DATA_WIDTH  edge weight
upd_valid  out  1  one-cycle pulse: dist[upd_node] was lowered
upd_node  out  ADDR_WIDTH  updated node (v)
upd_pred  out  ADDR_WIDTH  new predecessor (u)
upd_dist  out  DATA_WIDTH  new distance
mem_addr_a  out  ADDR_WIDTH  memory port A address
mem_data_a  out  DATA_WIDTH  port A write data
mem_we_a  out  1  port A write enable
mem_q_a  in  DATA_WIDTH  port A registered read data
mem_addr_b  out  ADDR_WIDTH  memory port B address
mem_data_b  out  DATA_WIDTH  port B write data
mem_we_b  out  1  port B write enable
mem_q_b  in  DATA_WIDTH  port B registered read data

Behaviour:
- Memory timing: an address driven in cycle t gives read data on mem_q_x in cycle t+1. A write returns write-through data, which the engine never relies on.
- FSM states: IDLE, INIT, RD, CMP.
- Reset: state IDLE; init counter = 0; all mem_we = 0; all addresses and data = 0; init_done = 0; upd_valid = 0; busy = 0; edge_ready = 0 during the reset cycle.
- Reset during INIT aborts the sweep; memory contents are then undefined and a fresh INIT is required. Reset during RD/CMP drops the edge with no write.
- IDLE:
  - edge_ready = 1.
  - start_init has priority over edge_valid in the same cycle. It latches src_node, clears the counter, goes to INIT, and the edge is not accepted (edge_ready = 0 that cycle).
  - Otherwise edge_valid && edge_ready latches u, v, w and goes to RD.
- INIT:
  - Port A only. Each cycle: mem_we_a = 1, mem_addr_a = cnt, mem_data_a = (cnt == src) ? 0 : INF; cnt increments.
  - After writing address N-1 (cnt wraps to 0), pulse init_done and return to IDLE. Total N cycles in INIT.
  - edge_ready = 0 throughout.
- RD: drive mem_addr_a = u and mem_addr_b = v with no writes, then go to CMP. u == v is legal (both ports read the same address).
- CMP:
  - du = mem_q_a, dv = mem_q_b.
  - Sum is computed at DATA_WIDTH+1 bits and saturated to INF.
  - Update condition: du != INF && sum < dv (strict).
  - On update, in this same cycle: mem_we_b = 1, mem_addr_b = v, mem_data_b = sum. Also upd_valid = 1 with upd_node = v, upd_pred = u, upd_dist = sum.
  - Always return to IDLE. Throughput is one edge per 3 cycles (IDLE, RD, CMP); latency from acceptance to write is 2 cycles.
- Self-loops never update: sum >= du = dv. Zero-weight edges update only on a strict decrease.
- The sum saturates at INF, so a computed INF never beats an existing INF.
- Port A never writes outside INIT. Port B never writes outside CMP, so there are no same-cycle dual-port write conflicts.
- upd_* fields hold their last value when upd_valid = 0.

Decomposition:
- Package dijkstra_pkg holds: the state enum (IDLE/INIT/RD/CMP), the INF constant function of DATA_WIDTH, and an edge_t struct {u, v, w}.
- One natural sub-module: sat_add_cmp. It is combinational: saturating add plus strict compare, producing sum and update.
- The FSM stays in the top module.

Test Plan:
- INIT with src=3, N=32, then read back all addresses: dist[3] = 0, all others = 255; init_done asserted exactly 32 cycles after the start_init cycle; busy high throughout.
- After INIT src=0, edges (0,1,5) then (1,2,7): upd pulses (node1, pred0, 5) then (node2, pred1, 12); memory holds 5 and 12.
- Edge (0,1,9) with dist[1] = 5: no write and no upd_valid. Edge (0,1,4): update to 4.
- Edge from unreachable u (dist = 255) with w = 0: no update. dist[u] = 250, w = 10 gives a saturated sum of 255, no update against dist[v] = 255.
- start_init and edge_valid asserted in the same cycle: INIT wins, edge_ready = 0, the edge stays pending and is accepted in the first IDLE cycle after init_done.
- Reset asserted in CMP of an improving edge and in mid-INIT (cnt = 10): no mem_we in the following cycle, state IDLE, all outputs at reset values.
